// File: rtl/guess_pkg.sv
// Shared constants for the guess game input conditioning and its FSM.
// Also used by the benches for both blocks.
package guess_pkg;
    localparam int NUM_BTN             = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int TICK_DIV_DEF        = 5;
endpackage : guess_pkg

// File: rtl/debounce_bit.sv
// One button lane: 2-flop synchronizer, run-length debounce, rising-edge press pulse.
// A debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM_CNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_r;
    logic          s2_r;
    logic          b_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, qualify and detect press; any disagreement break restarts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            b_r     <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            s1_r    <= raw;
            s2_r    <= s1_r;
            press_r <= 1'b0;
            if (s2_r == b_r) begin
                cnt_r <= '0;
            end else if (cnt_r == TERM_CNT) begin
                b_r     <= s2_r;
                press_r <= s2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level = b_r;
    assign press = press_r;
endmodule : debounce_bit

// File: rtl/guess_input_cond.sv
// Input conditioning for the guess game: debounced buttons, press pulses and
// a free-running game-step enable.
module guess_input_cond
    import guess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TICK_DIV        = TICK_DIV_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] b,
    output logic [NUM_BTN-1:0] b_press,
    output logic               en
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt_r;
    logic          en_r;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[gi]),
            .level (b[gi]),
            .press (b_press[gi])
        );
    end

    // Free-running step divider; en lands on the edge that wraps the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r <= '0;
            en_r       <= 1'b0;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= '0;
            en_r       <= 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
            en_r       <= 1'b0;
        end
    end

    assign en = en_r;
endmodule : guess_input_cond
